// File: rtl/x_bus_pkg.sv
// rtl/x_bus_pkg.sv - shared types and address map for the x bus responder
package x_bus_pkg;

  typedef enum logic {IDLE, BUSY} state_t;

  localparam int          PERIPH_BIT = 31;
  localparam logic [31:0] GPIO_ADDR  = 32'h8000_0000;
  localparam logic [31:0] CNT_ADDR   = 32'h8000_0004;

  // Align the addressed byte lane to bit 0, zero-filling the upper bytes.
  function automatic logic [31:0] byte_align(input logic [31:0] word, input logic [1:0] off);
    return word >> {off, 3'b000};
  endfunction

endpackage

// File: rtl/x_sp_ram.sv
// rtl/x_sp_ram.sv - single-port RAM, synchronous read, write-enable, no reset
module x_sp_ram #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/x_mem_responder.sv
// rtl/x_mem_responder.sv - single-beat bus responder: RAM, GPIO and cycle counter
module x_mem_responder
  import x_bus_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT        = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic        i_rnw,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_data,
  output logic        o_accept,
  output logic [31:0] o_data,
  output logic [31:0] o_gpio
);

  localparam int         AW      = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_M1 = 4'(WAIT - 1);

  state_t      r_state;
  logic [3:0]  r_wait;
  logic        r_accept;
  logic [31:0] r_gpio;
  logic [31:0] r_cycles;

  logic        w_periph;
  logic        w_sel_gpio;
  logic        w_sel_cnt;
  logic        w_ram_we;
  logic        w_gpio_we;
  logic [31:0] w_ram_rdata;
  logic [31:0] w_word;

  assign w_periph   = i_addr[PERIPH_BIT];
  assign w_sel_gpio = (i_addr[31:2] == GPIO_ADDR[31:2]);
  assign w_sel_cnt  = (i_addr[31:2] == CNT_ADDR[31:2]);

  // Writes commit on the edge that closes the accept cycle.
  assign w_ram_we  = r_accept && !i_rnw && !w_periph;
  assign w_gpio_we = r_accept && !i_rnw && w_sel_gpio;

  // r_accept is raised one step ahead so it is high exactly when the wait count reaches 0.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_wait   <= '0;
      r_accept <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_valid) begin
            r_state  <= BUSY;
            r_wait   <= WAIT_M1;
            r_accept <= (WAIT_M1 == 4'd0);
          end
        end
        BUSY: begin
          if (r_accept) begin
            r_state  <= IDLE;
            r_accept <= 1'b0;
          end else begin
            r_wait   <= r_wait - 4'd1;
            r_accept <= (r_wait == 4'd1);
          end
        end
        default: begin
          r_state  <= IDLE;
          r_accept <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_gpio <= '0;
    end else if (w_gpio_we) begin
      r_gpio <= i_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cycles <= '0;
    end else begin
      r_cycles <= r_cycles + 32'd1;
    end
  end

  x_sp_ram #(
    .DEPTH (DEPTH_WORDS),
    .WIDTH (32)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_ram_we),
    .i_addr  (i_addr[AW+1:2]),
    .i_wdata (i_data),
    .o_rdata (w_ram_rdata)
  );

  always_comb begin
    w_word = '0;
    if (!w_periph) begin
      w_word = w_ram_rdata;
    end else if (w_sel_gpio) begin
      w_word = r_gpio;
    end else if (w_sel_cnt) begin
      w_word = r_cycles;
    end
  end

  assign o_accept = r_accept;
  assign o_data   = r_accept ? byte_align(w_word, i_addr[1:0]) : 32'h0;
  assign o_gpio   = r_gpio;

endmodule

// File: tb/tb_x_mem_responder.sv
// tb/tb_x_mem_responder.sv - randomized self-checking bench for x_mem_responder (WAIT=1 and WAIT=3)
module tb_x_mem_responder;

  localparam int W0 = 1;
  localparam int W1 = 3;
  localparam logic [31:0] GPIO_A = 32'h8000_0000;
  localparam logic [31:0] CNT_A  = 32'h8000_0004;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid [2];
  logic        rnw   [2];
  logic [31:0] addr  [2];
  logic [31:0] wdat  [2];
  logic        acc   [2];
  logic [31:0] odat  [2];
  logic [31:0] gpio  [2];

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int c0     = 0;

  logic [31:0] mem_m  [int];
  logic [31:0] gpio_m [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  x_mem_responder #(.DEPTH_WORDS(1024), .WAIT(W0)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid[0]), .i_rnw(rnw[0]), .i_addr(addr[0]),
    .i_data(wdat[0]), .o_accept(acc[0]), .o_data(odat[0]), .o_gpio(gpio[0]));

  x_mem_responder #(.DEPTH_WORDS(1024), .WAIT(W1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid[1]), .i_rnw(rnw[1]), .i_addr(addr[1]),
    .i_data(wdat[1]), .o_accept(acc[1]), .o_data(odat[1]), .o_gpio(gpio[1]));

  a_hold0: assert property (@(posedge clk) disable iff (rst) (valid[0] && !acc[0]) |=> valid[0])
    else $error("protocol: dut0 request dropped before accept");
  a_hold1: assert property (@(posedge clk) disable iff (rst) (valid[1] && !acc[1]) |=> valid[1])
    else $error("protocol: dut1 request dropped before accept");

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  function automatic int wait_of(input int d);
    return (d == 0) ? W0 : W1;
  endfunction

  function automatic int key(input int d, input logic [31:0] a);
    return d * 4096 + int'(a[11:2]);
  endfunction

  function automatic logic [31:0] model_read(input int d, input logic [31:0] a, input int cacc);
    logic [31:0] w;
    if (a[31]) begin
      if (a[31:2] == GPIO_A[31:2])     w = gpio_m[d];
      else if (a[31:2] == CNT_A[31:2]) w = 32'(cacc - c0);
      else                             w = 32'h0;
    end else begin
      w = mem_m[key(d, a)];
    end
    return w >> (8 * a[1:0]);
  endfunction

  // Entered just after a rising edge with the request already driven.
  task automatic wait_acc(input int d, input string tag, output logic [31:0] rd,
                          output int lat, output int cacc);
    lat = -1; rd = 'x; cacc = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (acc[d]) begin
        lat = k - 1; rd = odat[d]; cacc = cyc;
        break;
      end
      check({tag, "_idle_data"}, odat[d], 32'h0);
    end
    if (lat < 0) check({tag, "_timeout"}, {31'h0, acc[d]}, 32'h1);
    @(posedge clk); #1;
  endtask

  task automatic op(input int d, input logic rw, input logic [31:0] a, input logic [31:0] wd,
                    input string tag, output logic [31:0] rd, output int cacc);
    int lat;
    valid[d] = 1'b1; rnw[d] = rw; addr[d] = a; wdat[d] = wd;
    wait_acc(d, tag, rd, lat, cacc);
    valid[d] = 1'b0;
    check({tag, "_lat"}, 32'(lat), 32'(wait_of(d)));
    if (rw) begin
      check({tag, "_rd"}, rd, model_read(d, a, cacc));
    end else if (!a[31]) begin
      mem_m[key(d, a)] = wd;
    end else if (a[31:2] == GPIO_A[31:2]) begin
      gpio_m[d] = wd;
    end
    check({tag, "_gpio"}, gpio[d], gpio_m[d]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin : stim
    logic [31:0] rd, rd2;
    int ca, cb, lat;
    int kind, idx;
    logic [31:0] up;
    for (int d = 0; d < 2; d++) begin
      valid[d] = 1'b0; rnw[d] = 1'b1; addr[d] = '0; wdat[d] = '0; gpio_m[d] = '0;
    end
    #2;
    check("rst_acc0", {31'h0, acc[0]}, 32'h0);
    check("rst_gpio1", gpio[1], 32'h0);
    repeat (3) @(posedge clk);
    #1; rst = 1'b0; c0 = cyc;
    for (int d = 0; d < 2; d++) begin
      check("rel_acc", {31'h0, acc[d]}, 32'h0);
      check("rel_data", odat[d], 32'h0);
      check("rel_gpio", gpio[d], 32'h0);
    end

    op(0, 1'b0, 32'h10, 32'hDEAD_BEEF, "w1_wr", rd, ca);
    op(0, 1'b1, 32'h10, 32'h0, "w1_rd", rd, ca);
    op(0, 1'b1, 32'h13, 32'h0, "w1_rd13", rd, ca);
    check("w1_rd13_abs", rd, 32'h0000_00DE);

    op(1, 1'b0, 32'h10, 32'hCAFE_F00D, "w3_wr", rd, ca);
    idle(2);
    op(1, 1'b1, 32'h10, 32'h0, "w3_rd", rd, ca);
    op(1, 1'b0, 32'h20, 32'h1234_ABCD, "b2b_wr", rd, ca);
    op(1, 1'b1, 32'h20, 32'h0, "b2b_rd", rd, ca);
    op(1, 1'b1, 32'h12, 32'h0, "b2b_rd2", rd, ca);

    op(0, 1'b0, GPIO_A, 32'h0000_00A5, "gpio_wr", rd, ca);
    check("gpio_abs", gpio[0], 32'h0000_00A5);
    op(0, 1'b1, GPIO_A, 32'h0, "gpio_rd", rd, ca);
    op(0, 1'b0, CNT_A, 32'hFFFF_0000, "cnt_wr", rd, ca);
    op(0, 1'b1, CNT_A, 32'h0, "cnt_rd1", rd, ca);
    idle(7);
    op(0, 1'b1, CNT_A, 32'h0, "cnt_rd2", rd2, cb);
    check("cnt_delta", rd2 - rd, 32'(cb - ca));

    op(0, 1'b0, 32'h0000_1000, 32'h5566_7788, "alias_wr", rd, ca);
    op(0, 1'b1, 32'h0000_0000, 32'h0, "alias_rd", rd, ca);
    check("alias_abs", rd, 32'h5566_7788);

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 40; i++) begin
        kind = $urandom_range(0, 5);
        idx  = $urandom_range(0, 15);
        up   = $urandom & 32'h7FFF_F000;
        case (kind)
          0, 1: op(d, 1'b0, up | 32'(idx << 2) | 32'($urandom_range(0, 3)), $urandom, "rnd_wr", rd, ca);
          2, 3: begin
            if (mem_m.exists(d * 4096 + idx))
              op(d, 1'b1, up | 32'(idx << 2) | 32'($urandom_range(0, 3)), 32'h0, "rnd_rd", rd, ca);
            else
              op(d, 1'b0, up | 32'(idx << 2), $urandom, "rnd_wr", rd, ca);
          end
          4: op(d, 1'($urandom_range(0, 1)), GPIO_A, $urandom, "rnd_gpio", rd, ca);
          default: op(d, 1'($urandom_range(0, 1)), GPIO_A | ($urandom & 32'hFC), $urandom, "rnd_per", rd, ca);
        endcase
        idle($urandom_range(0, 2));
      end
    end

    op(1, 1'b0, 32'h40, 32'h1111_1111, "pre_rst_wr", rd, ca);
    op(1, 1'b0, GPIO_A, 32'h0000_005A, "pre_rst_gpio", rd, ca);
    op(0, 1'b0, GPIO_A, 32'h0000_00A5, "pre_rst_gpio0", rd, ca);
    valid[1] = 1'b1; rnw[1] = 1'b0; addr[1] = 32'h40; wdat[1] = 32'h2222_2222;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("mid_rst_acc", {31'h0, acc[1]}, 32'h0);
    check("mid_rst_gpio1", gpio[1], 32'h0);
    check("mid_rst_gpio0", gpio[0], 32'h0);
    valid[1] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; c0 = cyc; gpio_m[0] = '0; gpio_m[1] = '0;
    op(1, 1'b1, 32'h40, 32'h0, "post_rst_rd", rd, ca);
    op(0, 1'b1, CNT_A, 32'h0, "post_rst_cnt", rd, ca);

    valid[1] = 1'b1; rnw[1] = 1'b1; addr[1] = 32'h40;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; c0 = cyc;
    wait_acc(1, "fresh", rd, lat, ca);
    valid[1] = 1'b0;
    check("fresh_lat", 32'(lat), 32'(W1));
    check("fresh_rd", rd, 32'h1111_1111);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
